// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one prescaled
// down-counting delay timer among CHANNELS requesters.
module timer_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SIZE     = 8,
  parameter int DIV      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         req,
  input  logic [CHANNELS*SIZE-1:0]    req_count,
  input  logic                        abort,
  output logic [CHANNELS-1:0]         ack,
  output logic [CHANNELS-1:0]         done,
  output logic                        busy,
  output logic [$clog2(CHANNELS)-1:0] active_ch,
  output logic [SIZE-1:0]             value
);

  localparam int CW = $clog2(CHANNELS);
  localparam int TW = SIZE + DIV;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  logic [TW-1:0]   ctr;
  logic [CW-1:0]   last_grant;
  logic [CW-1:0]   grant;
  logic [CW-1:0]   idx;
  logic            found;

  assign busy  = (state != S_IDLE);
  assign value = ctr[TW-1 -: SIZE];

  // Round-robin scan: first set req starting just after last_grant
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      idx = CW'((int'(last_grant) + i) % CHANNELS);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // Scheduler FSM with registered ack/done pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ctr        <= '0;
      ack        <= '0;
      done       <= '0;
      active_ch  <= '0;
      last_grant <= CW'(CHANNELS - 1);
    end else begin
      ack  <= '0;
      done <= '0;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            active_ch <= grant;
            ctr       <= {req_count[int'(grant)*SIZE +: SIZE],
                          {DIV{1'b0}}};
            ack       <= CHANNELS'(1) << grant;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            state      <= S_IDLE;
            last_grant <= active_ch;
          end else if (ctr == '0) begin
            state <= S_DONE;
            done  <= CHANNELS'(1) << active_ch;
          end else begin
            ctr <= ctr - TW'(1);
          end
        end
        S_DONE: begin
          last_grant <= active_ch;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed vectors and hand sequences
// for the shared delay timer arbiter.
module tb_timer_arbiter;

  localparam int CH = 4;
  localparam int SZ = 8;
  localparam int DV = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] req;
  logic [CH*SZ-1:0] req_count;
  logic          abort;
  logic [CH-1:0] ack;
  logic [CH-1:0] done;
  logic          busy;
  logic [1:0]    active_ch;
  logic [SZ-1:0] value;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         ch;
    int         count;
    logic [3:0] exp_ack;
    int         lat;
  } vec_t;

  vec_t vecs[5];

  timer_arbiter #(
    .CHANNELS(CH),
    .SIZE(SZ),
    .DIV(DV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_count(req_count),
    .abort(abort),
    .ack(ack),
    .done(done),
    .busy(busy),
    .active_ch(active_ch),
    .value(value)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_count(input int ch, input int c);
    req_count[ch*SZ +: SZ] = SZ'(c);
  endtask

  // cycles from now until ack appears (0 on timeout)
  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (|ack) begin
        n = i;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL ack_timeout: got none expected ack");
  endtask

  // cycles from now until done appears; busy must stay high
  task automatic wait_done(output int n, output logic bok);
    n = 0;
    bok = 1'b1;
    for (int i = 1; i <= 2000; i++) begin
      tick();
      if (!busy) bok = 1'b0;
      if (|done) begin
        n = i;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL done_timeout: got none expected done");
  endtask

  initial begin
    int   n;
    int   seen;
    logic bok;

    vecs[0] = '{1, 3,   4'b0010, 13};
    vecs[1] = '{3, 0,   4'b1000, 1};
    vecs[2] = '{0, 2,   4'b0001, 9};
    vecs[3] = '{2, 1,   4'b0100, 5};
    vecs[4] = '{1, 255, 4'b0010, 1021};

    rst = 1'b1;
    req = '0;
    abort = 1'b0;
    req_count = '0;
    tick();
    tick();
    check("rst_ack", 32'(ack), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_active_ch", 32'(active_ch), 0);
    check("rst_value", 32'(value), 0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      set_count(vecs[v].ch, vecs[v].count);
      req = 4'(1) << vecs[v].ch;
      wait_ack(n);
      check("vec_ack", 32'(ack), 32'(vecs[v].exp_ack));
      check("vec_value", 32'(value), 32'(vecs[v].count));
      req = '0;
      wait_done(n, bok);
      check("vec_latency", 32'(n), 32'(vecs[v].lat));
      check("vec_done", 32'(done), 32'(vecs[v].exp_ack));
      check("vec_busy", 32'(bok), 1);
      tick();
    end

    // round robin from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_count = 32'h0101_0101;
    req = 4'b0101;
    wait_ack(n);
    check("rr1_ack", 32'(ack), 32'b0001);
    check("rr1_active", 32'(active_ch), 0);
    req = 4'b0100;
    wait_done(n, bok);
    check("rr1_done", 32'(done), 32'b0001);
    wait_ack(n);
    check("rr2_gap", 32'(n), 2);
    check("rr2_ack", 32'(ack), 32'b0100);
    req = '0;
    wait_done(n, bok);
    check("rr2_done", 32'(done), 32'b0100);
    req = 4'b0101;
    wait_ack(n);
    check("rr3_gap", 32'(n), 2);
    check("rr3_ack", 32'(ack), 32'b0001);
    req = 4'b0100;
    wait_done(n, bok);
    wait_ack(n);
    check("rr4_ack", 32'(ack), 32'b0100);
    req = '0;
    wait_done(n, bok);
    tick();

    // held request is re-granted after one idle cycle
    req = 4'b0100;
    wait_ack(n);
    check("held_ack1", 32'(ack), 32'b0100);
    wait_done(n, bok);
    check("held_done1", 32'(done), 32'b0100);
    wait_ack(n);
    check("held_gap", 32'(n), 2);
    check("held_ack2", 32'(ack), 32'b0100);
    check("held_nodone", 32'(done), 0);
    req = '0;
    wait_done(n, bok);
    tick();

    // abort mid-run, pending ch0 granted next
    set_count(1, 5);
    req = 4'b0010;
    wait_ack(n);
    check("abort_ack", 32'(ack), 32'b0010);
    req = 4'b0001;
    seen = 0;
    repeat (4) begin
      tick();
      if (|done) seen++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (|done) seen++;
    check("abort_busy", 32'(busy), 0);
    check("abort_nodone", 32'(seen), 0);
    tick();
    check("abort_next_ack", 32'(ack), 32'b0001);
    req = '0;
    wait_done(n, bok);
    check("abort_next_done", 32'(done), 32'b0001);
    tick();

    // abort on the same edge as ctr==0 suppresses done
    set_count(2, 0);
    req = 4'b0100;
    wait_ack(n);
    req = '0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    seen = 0;
    if (|done) seen++;
    check("abort0_busy", 32'(busy), 0);
    repeat (3) begin
      tick();
      if (|done) seen++;
    end
    check("abort0_nodone", 32'(seen), 0);

    // abort has no effect in IDLE
    abort = 1'b1;
    req = 4'b0001;
    tick();
    check("idle_abort_ack", 32'(ack), 32'b0001);
    abort = 1'b0;
    req = '0;
    wait_done(n, bok);
    check("idle_abort_done", 32'(done), 32'b0001);
    tick();

    // reset mid-run drops the job
    set_count(1, 3);
    req = 4'b0010;
    wait_ack(n);
    req = '0;
    check("mid_value3", 32'(value), 3);
    tick();
    check("mid_value2", 32'(value), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_ack", 32'(ack), 0);
    check("mid_done", 32'(done), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_active", 32'(active_ch), 0);
    check("mid_value", 32'(value), 0);
    seen = 0;
    repeat (5) begin
      tick();
      if (|done) seen++;
    end
    check("mid_nodone", 32'(seen), 0);
    set_count(3, 0);
    req = 4'b1000;
    wait_ack(n);
    check("mid_next_ack", 32'(ack), 32'b1000);
    check("mid_next_active", 32'(active_ch), 3);
    req = '0;
    wait_done(n, bok);
    check("mid_next_lat", 32'(n), 1);
    check("mid_next_done", 32'(done), 32'b1000);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
